// File: rtl/wimax_pkg.sv
// Shared WiMAX PHY definitions: convolutional-code block sizes, generator
// polynomials and the encoder state type.
package wimax_pkg;

  localparam int unsigned CC_N_IN  = 96;
  localparam int unsigned CC_N_OUT = 2 * CC_N_IN;

  // Tap order is {u, s1, s2, s3, s4, s5, s6}, MSB first
  localparam logic [6:0] CC_G1 = 7'o171;
  localparam logic [6:0] CC_G2 = 7'o133;

  typedef enum logic [1:0] {
    FILL,
    ENCODE,
    HOLD
  } cc_state_t;

endpackage

// File: rtl/cc_core.sv
// K=7 convolutional core: 6-bit shift register with tail-biting preload and
// combinational X/Y outputs for the current input bit.
module cc_core
  import wimax_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       load,
  input  logic       shift,
  input  logic [5:0] tail,
  input  logic       u,
  output logic       x,
  output logic       y
);

  // sreg[5] holds s1 (previous bit), sreg[0] holds s6
  logic [5:0] sreg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= tail;
    end else if (shift) begin
      sreg <= {u, sreg[5:1]};
    end
  end

  assign x = ^({u, sreg} & CC_G1);
  assign y = ^({u, sreg} & CC_G2);

endmodule

// File: rtl/fec_cc_encoder.sv
// Tail-biting rate-1/2 K=7 encoder: serial 96-bit fill, bit-serial encode,
// parallel 192-bit coded block. FEC_CC_PINGPONG_EN adds a second input buffer.
module fec_cc_encoder
  import wimax_pkg::*;
#(
  parameter  int unsigned N_IN  = CC_N_IN,
  localparam int unsigned N_OUT = N_IN * (CC_N_OUT / CC_N_IN)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [N_OUT-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready
);

  localparam int unsigned     CW   = $clog2(N_IN);
  localparam logic [CW-1:0]   LAST = CW'(N_IN - 1);

  cc_state_t       state;
  logic [CW-1:0]   wr_cnt;
  logic [CW-1:0]   enc_cnt;
  logic [CW:0]     pos;
  logic            primed;
  logic            take;
  logic            last_in;
  logic            hold_done;
  logic [N_IN-1:0] enc_word;
  logic [5:0]      load_tail;
  logic            core_load;
  logic            core_shift;
  logic            x_bit;
  logic            y_bit;

  assign take      = data_in_valid && data_in_ready;
  assign last_in   = take && (wr_cnt == LAST);
  assign hold_done = (state == HOLD) && data_out_ready;
  assign pos       = {enc_cnt, 1'b0};

`ifdef FEC_CC_PINGPONG_EN
  logic [N_IN-1:0] ubuf [2];
  logic [1:0]      full;
  logic            wr_sel;
  logic            rd_sel;

  assign data_in_ready = !(&full);
  assign enc_word      = ubuf[rd_sel];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ubuf   <= '{default: '0};
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
    end else begin
      if (take) begin
        ubuf[wr_sel][wr_cnt] <= data_in;
        if (last_in) begin
          wr_cnt       <= '0;
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      // The held buffer is never the one being filled, so these never collide
      if (hold_done) begin
        full[rd_sel] <= 1'b0;
        if (full[~rd_sel] || last_in) rd_sel <= ~rd_sel;
      end else if (state == FILL && last_in) begin
        rd_sel <= wr_sel;
      end
    end
  end
`else
  logic [N_IN-1:0] ubuf;

  assign data_in_ready = (state == FILL);
  assign enc_word      = ubuf;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ubuf   <= '0;
      wr_cnt <= '0;
    end else if (take) begin
      ubuf[wr_cnt] <= data_in;
      wr_cnt       <= last_in ? '0 : wr_cnt + 1'b1;
    end
  end
`endif

  // A buffer already full at HOLD exit is preloaded on that same edge,
  // skipping the separate preload cycle so blocks can run back to back.
  always_comb begin
    core_load  = 1'b0;
    core_shift = 1'b0;
    load_tail  = enc_word[N_IN-1 -: 6];
    if (state == ENCODE) begin
      core_load  = !primed;
      core_shift = primed;
    end
`ifdef FEC_CC_PINGPONG_EN
    if (hold_done && full[~rd_sel]) begin
      core_load = 1'b1;
      load_tail = ubuf[~rd_sel][N_IN-1 -: 6];
    end
`endif
  end

  cc_core u_core (
    .clk    (clk),
    .resetN (resetN),
    .load   (core_load),
    .shift  (core_shift),
    .tail   (load_tail),
    .u      (enc_word[enc_cnt]),
    .x      (x_bit),
    .y      (y_bit)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= FILL;
      enc_cnt        <= '0;
      primed         <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (last_in) begin
            state   <= ENCODE;
            enc_cnt <= '0;
            primed  <= 1'b0;
          end
        end
        ENCODE: begin
          if (!primed) begin
            primed <= 1'b1;
          end else begin
            data_out[pos +: 2] <= {y_bit, x_bit};
            if (enc_cnt == LAST) begin
              state          <= HOLD;
              data_out_valid <= 1'b1;
            end else begin
              enc_cnt <= enc_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (data_out_ready) begin
            data_out_valid <= 1'b0;
            enc_cnt        <= '0;
`ifdef FEC_CC_PINGPONG_EN
            if (full[~rd_sel]) begin
              state  <= ENCODE;
              primed <= 1'b1;
            end else if (last_in) begin
              state  <= ENCODE;
              primed <= 1'b0;
            end else begin
              state <= FILL;
            end
`else
            state <= FILL;
`endif
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fec_cc_encoder.sv
// Self-checking bench for fec_cc_encoder: vector table, random blocks against a
// modular-index reference encoder, HOLD stall, mid-encode reset, ping-pong stream.
module tb_fec_cc_encoder;

  logic         clk;
  logic         resetN;
  logic         data_in;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [191:0] data_out;
  logic         data_out_valid;
  logic         data_out_ready;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned acc_cyc;

`ifdef FEC_CC_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  fec_cc_encoder dut (
    .clk            (clk),
    .resetN         (resetN),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [95:0]  blk;
    logic [191:0] exp;
    bit           gaps;
    bit           rdy_early;
  } vec_t;

  vec_t vec [4];

  // Reference: X/Y from the generator taps with u(i-k) taken modulo the block
  function automatic logic [191:0] ref_enc(input logic [95:0] u);
    logic [191:0] r = '0;
    for (int i = 0; i < 96; i++) begin
      r[2*i]   = u[i] ^ u[(i+95)%96] ^ u[(i+94)%96] ^ u[(i+93)%96] ^ u[(i+90)%96];
      r[2*i+1] = u[i] ^ u[(i+94)%96] ^ u[(i+93)%96] ^ u[(i+91)%96] ^ u[(i+90)%96];
    end
    return r;
  endfunction

  function automatic logic [95:0] rand_blk();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; acc_cyc = edge count of the u95 acceptance
  task automatic send_block(input logic [95:0] u, input bit gaps);
    int unsigned i = 0;
    int unsigned guard = 0;
    bit drive;
    logic rdy;
    while (i < 96) begin
      if (guard++ > 2000) begin
        total++; bad++;
        $display("FAIL send_timeout: accepted=%0d want=96", i);
        break;
      end
      drive = !gaps || ($urandom_range(0, 3) != 0);
      data_in_valid = drive;
      data_in = drive ? u[i] : 1'($urandom);
      rdy = data_in_ready;
      @(negedge clk);
      if (drive && rdy) i++;
    end
    data_in_valid = 1'b0;
    data_in = 1'($urandom);
    acc_cyc = cyc;
  endtask

  task automatic get_block(input string name, input logic [191:0] exp,
                           input bit lat, input int unsigned hold);
    int unsigned n = 0;
    while (!data_out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!data_out_valid) begin
      total++; bad++;
      $display("FAIL %s_timeout: data_out_valid=0 want=1", name);
      return;
    end
    if (lat) chk({name, "_lat"}, 192'(cyc - acc_cyc), 192'd97);
    chk(name, data_out, exp);
    for (int unsigned k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({name, "_hold_data"}, data_out, exp);
      chk({name, "_hold_valid"}, 192'(data_out_valid), 192'd1);
      chk({name, "_hold_inrdy"}, 192'(data_in_ready), 192'(PP));
    end
    data_out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_valid_drop"}, 192'(data_out_valid), 192'd0);
    chk({name, "_inrdy_after"}, 192'(data_in_ready), 192'd1);
    data_out_ready = 1'b0;
  endtask

`ifdef FEC_CC_PINGPONG_EN
  logic [95:0] pp_blk [4];
  int unsigned pp_b, pp_i, pp_got, pp_last, pp_t;
  logic        pp_rdy;
`endif

  initial begin
    vec[0] = '{96'h0, 192'h0, 1'b0, 1'b1};
    vec[1] = '{96'h1, 192'h38F7, 1'b0, 1'b0};
    vec[2] = '{{1'b1, 95'h0}, {2'b11, 178'h0, 12'hE3D}, 1'b1, 1'b0};
    vec[3] = '{{96{1'b1}}, {192{1'b1}}, 1'b1, 1'b1};

    resetN = 1'b0;
    data_in = 1'b0;
    data_in_valid = 1'b0;
    data_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 192'h0);
    chk("rst_valid", 192'(data_out_valid), 192'd0);
    chk("rst_inrdy", 192'(data_in_ready), 192'd1);
    resetN = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      data_out_ready = vec[k].rdy_early;
      send_block(vec[k].blk, vec[k].gaps);
      get_block($sformatf("vec%0d", k), vec[k].exp, 1'b1, 0);
    end

    for (int k = 0; k < 6; k++) begin
      logic [95:0] u;
      u = rand_blk();
      send_block(u, 1'b1);
      get_block($sformatf("rand%0d", k), ref_enc(u), 1'b1, 0);
    end

    begin
      logic [95:0] u;
      u = rand_blk();
      send_block(u, 1'b0);
      get_block("stall", ref_enc(u), 1'b1, 50);
    end

    // Reset during encode cycle ~40, then a clean u0=1 block
    send_block({96{1'b1}}, 1'b0);
    repeat (42) @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_data", data_out, 192'h0);
    chk("midrst_valid", 192'(data_out_valid), 192'd0);
    chk("midrst_inrdy", 192'(data_in_ready), 192'd1);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    send_block(96'h1, 1'b0);
    get_block("after_rst", 192'h38F7, 1'b1, 0);

`ifdef FEC_CC_PINGPONG_EN
    for (int b = 0; b < 4; b++) pp_blk[b] = rand_blk();
    data_out_ready = 1'b1;
    pp_got = 0;
    fork
      begin
        pp_b = 0; pp_i = 0;
        for (int g = 0; g < 5000 && pp_b < 4; g++) begin
          data_in_valid = 1'b1;
          data_in = pp_blk[pp_b][pp_i];
          pp_rdy = data_in_ready;
          @(negedge clk);
          if (pp_rdy) begin
            if (pp_i == 95) begin pp_i = 0; pp_b++; end
            else pp_i++;
          end
        end
        data_in_valid = 1'b0;
      end
      begin
        pp_t = 0;
        while (pp_got < 4 && pp_t < 3000) begin
          @(negedge clk);
          pp_t++;
          if (data_out_valid) begin
            chk($sformatf("pp_blk%0d", pp_got), data_out, ref_enc(pp_blk[pp_got]));
            if (pp_got > 0) chk($sformatf("pp_gap%0d", pp_got), 192'(pp_t - pp_last), 192'd97);
            pp_last = pp_t;
            pp_got++;
          end
        end
        if (pp_got < 4) begin
          total++; bad++;
          $display("FAIL pp_timeout: blocks=%0d want=4", pp_got);
        end
      end
    join
    data_out_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fec_cc_encoder.md
# fec_cc_encoder

Tail-biting rate-1/2 convolutional encoder (K=7, generators 171/133 octal) for the WiMAX PHY transmit chain. It sits directly upstream of the block interleaver. It collects a 96-bit serial block from the randomizer and encodes it bit-serially over 96 cycles. It presents the resulting 192-bit coded block in parallel, the same width and bit order the interleaver's `data_in` expects.

## Interface
- `N_IN`, default 96: uncoded bits per block (QPSK-1/2 slot).
- `N_OUT`, fixed at 2*`N_IN` (192): coded bits per block. Not independently settable.
- `clk` input, 1 bit: single clock, rising edge.
- `resetN` input, 1 bit: asynchronous, active-low reset.
- `data_in` input, 1 bit: serial uncoded bit. The first bit of a block is u0.
- `data_in_valid` input, 1 bit: `data_in` is valid this cycle.
- `data_in_ready` output, 1 bit: encoder accepts `data_in` this cycle.
- `data_out` output, `N_OUT` bits: coded block. Bit 2i = Xi, bit 2i+1 = Yi.
- `data_out_valid` output, 1 bit: `data_out` holds a complete block.
- `data_out_ready` input, 1 bit: downstream consumes the block.

## Operation
- Input transfer: a bit is transferred on a rising edge where `data_in_valid && data_in_ready`. It is stored at index `wr_cnt`, then `wr_cnt` increments (7 bits, range 0..95).
- State machine states: FILL, ENCODE, HOLD.
  - FILL → ENCODE on the edge that accepts u95.
  - ENCODE → HOLD after 96 encode cycles.
  - HOLD → FILL (or → ENCODE, see Configuration) on the edge where `data_out_ready` is high.
- Tail-biting: on entry to ENCODE, the shift register s[1..6] is preloaded with {u95, u94, u93, u92, u91, u90}. Here s[k] = u(i-k).
- Per encode cycle i (0..95):
  - Xi = ui ^ s1 ^ s2 ^ s3 ^ s6 (G1 = 171).
  - Yi = ui ^ s2 ^ s3 ^ s5 ^ s6 (G2 = 133).
  - Xi and Yi are written to `data_out` bits 2i and 2i+1.
  - The register then shifts in ui.
- `data_out` is built in place and stays stable through HOLD. Bits with index 2i and above are don't-care before HOLD.
- Reset (asynchronous, any state, including mid-FILL and mid-ENCODE):
  - state = FILL; counters = 0; shift register = 0; buffers are cleared.
  - `data_out` = 0, `data_out_valid` = 0, `data_in_ready` = 1.
  - Any partial block is discarded.
- `data_in_valid` low during FILL stalls the fill without losing bits. No timeout applies.
- `data_in` is ignored whenever `data_in_ready` is 0.

## Timing
- `data_in_ready` is 1 in FILL and 0 in ENCODE and HOLD (without the ping-pong feature).
- Latency: if u95 is accepted at edge N, `data_out_valid` rises after edge N+97. That is one preload cycle plus 96 encode cycles.
- `data_out_valid` stays high until the first edge with `data_out_ready` = 1. It drops after that edge.
- Earliest next-block acceptance (without ping-pong): the edge after the output handshake.
- `data_out_ready` outside HOLD has no effect.
- Sustained throughput without ping-pong: one block per (96 + 98) cycles.

## Configuration
- Macro: `FEC_CC_PINGPONG_EN`.
- Defined: two 96-bit input buffers.
  - FILL of buffer B proceeds during ENCODE or HOLD of buffer A.
  - `data_in_ready` = 0 only while both buffers are full.
  - HOLD exits to ENCODE immediately if the other buffer is full. Otherwise it exits to FILL.
  - Buffer select toggles on each FILL → ENCODE transition.
  - With `data_out_ready` tied high, back-to-back blocks emerge every 97 cycles.
- Undefined: a single buffer with the behaviour described above.
- Port list is identical in both builds.

## Structure
- Shared package `wimax_pkg` contains:
  - `CC_N_IN` (96), `CC_N_OUT` (192).
  - `CC_G1` (7'o171), `CC_G2` (7'o133).
  - Typedef `cc_state_t` {FILL, ENCODE, HOLD}.
- Sub-module `cc_core`: 6-bit shift register with preload, shift enable, and combinational X/Y outputs. The top level owns the buffers, counters, FSM, and handshakes.

## Test plan
- All-zero block, `data_out_ready` = 1 → `data_out` = 192'h0, `data_out_valid` pulses once, 97 cycles after u95.
- u0 = 1, all other bits 0 → `data_out` = 192'h38F7.
- u95 = 1, all other bits 0 (wrap check) → `data_out` = {2'b11, 178'h0, 12'hE3D}. Bits 0, 2, 3, 4, 5, 9, 10, 11, 190, 191 are set.
- `data_out_ready` held low for 50 cycles in HOLD → `data_out` is stable, `data_out_valid` stays 1, and `data_in_ready` stays 0 (single buffer).
- `resetN` pulsed low at encode cycle 40 → all outputs go to 0 immediately and `data_in_ready` = 1. A fresh u0 = 1 block then yields 192'h38F7.
- `FEC_CC_PINGPONG_EN` build, continuous `data_in_valid`, `data_out_ready` = 1 → blocks spaced 97 cycles apart, each matching a golden model, no dropped bits.
